// File: rtl/data_cache_pkg.sv
// Shared definitions for the L1 data cache: block geometry, load/store encodings, FSM states.
package data_cache_pkg;

    localparam int unsigned CACHE_BLOCK_BYTES = 16;

    // Load funct3 encodings (READ_EN[2:0])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store size encodings (WRITE_EN[1:0])
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_ALLOCATE,
        ST_UPDATE
    } cache_state_e;

endpackage

// File: rtl/data_cache_if.sv
// Block-transfer bus between the data cache (master) and data memory (slave).
interface data_cache_if;

    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] MEM_READ_DATA;
    logic         MEM_BUSY_WAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA,
        input  MEM_READ_DATA, MEM_BUSY_WAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA,
        output MEM_READ_DATA, MEM_BUSY_WAIT
    );

endinterface

// File: rtl/data_cache_lane_align.sv
// Byte-lane logic for one 32-bit word: load extract/extend and store byte-merge.
module cache_lane_align
    import data_cache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{byte_off, 3'b000} +: 8];
    assign half_sel = byte_off[1] ? word[31:16] : word[15:0];

    // Load path: pick the addressed byte/half and sign- or zero-extend.
    always_comb begin
        load_data = word;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
    end

    // Store path: overlay right-justified store data onto the addressed lanes.
    always_comb begin
        merged_word = word;
        case (size)
            SZ_B: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
            SZ_H: begin
                if (byte_off[1]) merged_word[31:16] = store_data[15:0];
                else             merged_word[15:0]  = store_data[15:0];
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with one 128-bit block per memory handshake.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned LINES       = 8,
    parameter int unsigned BLOCK_BYTES = CACHE_BLOCK_BYTES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_EN,
    input  logic [2:0]  WRITE_EN,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY_WAIT,
    data_cache_if.master mem
);

    localparam int unsigned IDXW   = $clog2(LINES);
    localparam int unsigned TAGW   = 28 - IDXW;
    localparam int unsigned LINE_W = BLOCK_BYTES * 8;

    cache_state_e state_q, state_d;

    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] data_d [LINES];
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [TAGW-1:0]   tag_d  [LINES];
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [LINE_W-1:0] fill_q, fill_d;
    logic [31:0]       read_data_q, read_data_d;

    logic            req;
    logic            is_write;
    logic            hit;
    logic            access_ok;
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] addr_tag;
    logic [1:0]      word_sel;
    logic [31:0]     cur_word;
    logic [31:0]     load_word;
    logic [31:0]     merged_word;

    assign idx      = ADDR[4 +: IDXW];
    assign addr_tag = ADDR[31:4+IDXW];
    assign word_sel = ADDR[3:2];
    assign req      = READ_EN[3] | WRITE_EN[2];
    assign is_write = WRITE_EN[2];
    assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign cur_word = data_q[idx][{word_sel, 5'b00000} +: 32];

    assign BUSY_WAIT = req && (!hit || state_q != ST_IDLE);
    assign access_ok = req && !BUSY_WAIT;

    cache_lane_align u_align (
        .word        (cur_word),
        .byte_off    (ADDR[1:0]),
        .funct3      (READ_EN[2:0]),
        .size        (WRITE_EN[1:0]),
        .store_data  (WRITE_DATA),
        .load_data   (load_word),
        .merged_word (merged_word)
    );

    // Hits complete combinationally; otherwise hold the last load result.
    assign READ_DATA = (access_ok && !is_write) ? load_word : read_data_q;

    // Next-state, array update and memory handshake decode.
    always_comb begin
        state_d            = state_q;
        data_d             = data_q;
        tag_d              = tag_q;
        valid_d            = valid_q;
        dirty_d            = dirty_q;
        fill_d             = fill_q;
        read_data_d        = read_data_q;
        mem.MEM_READ       = 1'b0;
        mem.MEM_WRITE      = 1'b0;
        mem.MEM_ADDR       = '0;
        mem.MEM_WRITE_DATA = '0;

        case (state_q)
            ST_IDLE: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? ST_WRITEBACK : ST_ALLOCATE;
                end else if (access_ok) begin
                    if (is_write) begin
                        data_d[idx][{word_sel, 5'b00000} +: 32] = merged_word;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        read_data_d = load_word;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem.MEM_WRITE      = 1'b1;
                mem.MEM_ADDR       = {tag_q[idx], idx};
                mem.MEM_WRITE_DATA = data_q[idx];
                if (!mem.MEM_BUSY_WAIT) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                mem.MEM_READ = 1'b1;
                mem.MEM_ADDR = ADDR[31:4];
                if (!mem.MEM_BUSY_WAIT) begin
                    fill_d  = mem.MEM_READ_DATA;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                data_d[idx]  = fill_q;
                tag_d[idx]   = addr_tag;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, valid/dirty bits and held load result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            read_data_q <= read_data_d;
        end
    end

    // Tag/data arrays and refill buffer are not cleared by reset.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
        tag_q  <= tag_d;
        fill_q <= fill_d;
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache with a fixed-latency block memory model.
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int unsigned TMEM = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  READ_EN;
    logic [2:0]  WRITE_EN;
    logic [31:0] ADDR;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;

    data_cache_if mem_bus();

    data_cache #(.LINES(8), .BLOCK_BYTES(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ_EN    (READ_EN),
        .WRITE_EN   (WRITE_EN),
        .ADDR       (ADDR),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSY_WAIT  (BUSY_WAIT),
        .mem        (mem_bus)
    );

    always #5 CLK = ~CLK;

    // Memory model: a request completes after TMEM cycles, busy on all but the last.
    logic [127:0] mem [16];
    int unsigned  mcnt = 0;
    bit           mem_loaded = 1'b0;
    logic         mreq;

    assign mreq = mem_bus.MEM_READ | mem_bus.MEM_WRITE;
    assign mem_bus.MEM_BUSY_WAIT = mreq && (mcnt != TMEM - 1);
    assign mem_bus.MEM_READ_DATA = mem[mem_bus.MEM_ADDR[3:0]];

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0]  <= {96'h0, 32'h00C0FFEE};
            mem[4]  <= {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
            mem[8]  <= {96'h0, 32'h08080808};
            mem[12] <= {32'h7FFF0000, 32'h00000000, 32'h00000000, 32'h80010000};
            mem_loaded <= 1'b1;
        end else if (!mreq) begin
            mcnt <= 0;
        end else if (mcnt == TMEM - 1) begin
            mcnt <= 0;
            if (mem_bus.MEM_WRITE) mem[mem_bus.MEM_ADDR[3:0]] <= mem_bus.MEM_WRITE_DATA;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    typedef struct {
        string       name;
        int          bw;
        logic [31:0] data;
        bit          chk;
    } rsp_t;

    typedef struct {
        string        name;
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } mrq_t;

    rsp_t rsp_q[$];
    mrq_t mrq_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b1;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // CPU-side monitor: completed accesses pop the scoreboard; idle cycles check hold behaviour.
    int          bw_cnt = 0;
    logic [31:0] last_rd = '0;
    bit          last_known = 1'b1;

    always @(negedge CLK) begin : cpu_mon
        rsp_t r;
        if (RESET) begin
            bw_cnt     = 0;
            last_rd    = '0;
            last_known = 1'b1;
        end else if ((READ_EN[3] || WRITE_EN[2]) && mon_on) begin
            if (BUSY_WAIT) begin
                bw_cnt++;
            end else begin
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected access completion at addr %0h", ADDR);
                end else begin
                    r = rsp_q.pop_front();
                    check({r.name, " busy cycles"}, 128'(bw_cnt), 128'(r.bw));
                    if (r.chk) begin
                        check({r.name, " data"}, READ_DATA, r.data);
                        last_rd    = r.data;
                        last_known = 1'b1;
                    end else begin
                        last_known = 1'b0;
                    end
                end
                bw_cnt = 0;
            end
        end else if (!(READ_EN[3] || WRITE_EN[2])) begin
            check("idle busy_wait", BUSY_WAIT, 1'b0);
            if (last_known) check("idle read_data hold", READ_DATA, last_rd);
        end
    end

    // Memory-side monitor: each completed block transfer pops the memory scoreboard.
    always @(negedge CLK) begin : mem_mon
        mrq_t m;
        if (!RESET && mreq) begin
            check("mem read/write exclusive", {mem_bus.MEM_READ, mem_bus.MEM_WRITE}, 2'b10 >> mem_bus.MEM_WRITE);
            if (!mem_bus.MEM_BUSY_WAIT) begin
                if (mrq_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected mem transfer wr=%0b addr %0h", mem_bus.MEM_WRITE, mem_bus.MEM_ADDR);
                end else begin
                    m = mrq_q.pop_front();
                    check({m.name, " op"}, mem_bus.MEM_WRITE, m.wr);
                    check({m.name, " addr"}, mem_bus.MEM_ADDR, m.addr);
                    if (m.wr) check({m.name, " wdata"}, mem_bus.MEM_WRITE_DATA, m.wdata);
                end
            end
        end
    end

    task automatic exp_mem(input string name, input bit wr, input logic [27:0] a, input logic [127:0] wd);
        mrq_t m;
        m.name = name; m.wr = wr; m.addr = a; m.wdata = wd;
        mrq_q.push_back(m);
    endtask

    task automatic access(input string name, input logic [3:0] re, input logic [2:0] we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int bw, input logic [31:0] exp, input bit chk);
        rsp_t r;
        bit   done;
        r.name = name; r.bw = bw; r.data = exp; r.chk = chk;
        rsp_q.push_back(r);
        READ_EN = re; WRITE_EN = we; ADDR = a; WRITE_DATA = wd;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge CLK);
            if (!BUSY_WAIT) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy_wait still high after 200 cycles", name);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
        @(posedge CLK); #1;
        READ_EN = '0; WRITE_EN = '0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; READ_EN = '0; WRITE_EN = '0; ADDR = '0; WRITE_DATA = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        @(negedge CLK);
        check("reset busy_wait", BUSY_WAIT, 1'b0);
        check("reset read_data", READ_DATA, 32'h0);
        check("reset mem_read", mem_bus.MEM_READ, 1'b0);
        check("reset mem_write", mem_bus.MEM_WRITE, 1'b0);
        check("reset mem_addr", mem_bus.MEM_ADDR, 28'h0);
        check("reset mem_wdata", mem_bus.MEM_WRITE_DATA, 128'h0);
        @(posedge CLK); #1;

        // Cold fill, then hit
        exp_mem("fill 0x40", 1'b0, 28'h4, '0);
        access("LW 0x40 cold", {1'b1, F3_LW}, 3'b0, 32'h40, 32'h0, 7, 32'hDEADBEEF, 1'b1);
        access("LW 0x40 hit",  {1'b1, F3_LW}, 3'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 1'b1);

        // Byte store and extended loads
        access("SB 0x41",  4'b0, {1'b1, SZ_B}, 32'h41, 32'h00000080, 0, 32'h0, 1'b0);
        access("LB 0x41",  {1'b1, F3_LB},  3'b0, 32'h41, 32'h0, 0, 32'hFFFFFF80, 1'b1);
        access("LBU 0x41", {1'b1, F3_LBU}, 3'b0, 32'h41, 32'h0, 0, 32'h00000080, 1'b1);
        access("LW 0x40 merged", {1'b1, F3_LW}, 3'b0, 32'h40, 32'h0, 0, 32'hDEAD80EF, 1'b1);
        access("LB 0x43",  {1'b1, F3_LB},  3'b0, 32'h43, 32'h0, 0, 32'hFFFFFFDE, 1'b1);
        access("LBU 0x40", {1'b1, F3_LBU}, 3'b0, 32'h40, 32'h0, 0, 32'h000000EF, 1'b1);

        // Dirty victim on a conflicting index
        access("SW 0x40", 4'b0, {1'b1, SZ_W}, 32'h40, 32'h12345678, 0, 32'h0, 1'b0);
        exp_mem("writeback 0x40", 1'b1, 28'h4, {32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678});
        exp_mem("fill 0xC0", 1'b0, 28'hC, '0);
        access("LW 0xC0 dirty miss", {1'b1, F3_LW}, 3'b0, 32'hC0, 32'h0, 12, 32'h80010000, 1'b1);

        // Halfword loads
        access("LH 0xC2",  {1'b1, F3_LH},  3'b0, 32'hC2, 32'h0, 0, 32'hFFFF8001, 1'b1);
        access("LHU 0xC2", {1'b1, F3_LHU}, 3'b0, 32'hC2, 32'h0, 0, 32'h00008001, 1'b1);
        access("LH 0xC0",  {1'b1, F3_LH},  3'b0, 32'hC0, 32'h0, 0, 32'h00000000, 1'b1);
        access("LH 0xCE",  {1'b1, F3_LH},  3'b0, 32'hCE, 32'h0, 0, 32'h00007FFF, 1'b1);

        // Read and write together: the store wins
        exp_mem("fill 0x44", 1'b0, 28'h4, '0);
        access("SW+LW 0x44", {1'b1, F3_LW}, {1'b1, SZ_W}, 32'h44, 32'hA5A5A5A5, 7, 32'h0, 1'b0);
        access("LW 0x44", {1'b1, F3_LW}, 3'b0, 32'h44, 32'h0, 0, 32'hA5A5A5A5, 1'b1);
        access("LW 0x40 after refill", {1'b1, F3_LW}, 3'b0, 32'h40, 32'h0, 0, 32'h12345678, 1'b1);

        // Reset in the middle of a refill
        mon_on = 1'b0;
        READ_EN = {1'b1, F3_LW}; ADDR = 32'h50;
        @(negedge CLK);
        @(negedge CLK);
        check("allocate mem_read", mem_bus.MEM_READ, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b1; READ_EN = '0;
        @(posedge CLK); #1;
        RESET = 1'b0; mon_on = 1'b1;
        @(negedge CLK);
        check("post-reset mem_read", mem_bus.MEM_READ, 1'b0);
        check("post-reset mem_write", mem_bus.MEM_WRITE, 1'b0);
        check("post-reset busy_wait", BUSY_WAIT, 1'b0);
        @(posedge CLK); #1;

        // Dirty line 4 was dropped; memory copy returns
        exp_mem("refill 0x44", 1'b0, 28'h4, '0);
        access("LW 0x44 after reset", {1'b1, F3_LW}, 3'b0, 32'h44, 32'h0, 7, 32'h11111111, 1'b1);

        // Index wrap on line 0
        exp_mem("fill 0x000", 1'b0, 28'h0, '0);
        access("LW 0x000", {1'b1, F3_LW}, 3'b0, 32'h000, 32'h0, 7, 32'h00C0FFEE, 1'b1);
        exp_mem("fill 0x080", 1'b0, 28'h8, '0);
        access("LW 0x080", {1'b1, F3_LW}, 3'b0, 32'h080, 32'h0, 7, 32'h08080808, 1'b1);
        exp_mem("refill 0x000", 1'b0, 28'h0, '0);
        access("LW 0x000 again", {1'b1, F3_LW}, 3'b0, 32'h000, 32'h0, 7, 32'h00C0FFEE, 1'b1);

        repeat (3) @(posedge CLK);
        check("rsp queue drained", 128'(rsp_q.size()), 128'd0);
        check("mem queue drained", 128'(mrq_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
